// File: rtl/ffra_pkg.sv
// Shared constants and helpers for the ffra multiply-add/accumulate unit.
package ffra_pkg;
  localparam logic ACC_LOAD = 1'b0;
  localparam logic ACC_ADD  = 1'b1;
  localparam int   EXT_W    = 64;

  function automatic int acc_w(input int bits, input int guard);
    return 2 * bits + guard;
  endfunction

  // Extend the low w bits of v to EXT_W, sign- or zero-filling above bit w-1.
  function automatic logic [EXT_W-1:0] ext(input logic [EXT_W-1:0] v, input int w,
                                           input bit sgn);
    logic [EXT_W-1:0] mask;
    logic [5:0]       msb;
    mask = {EXT_W{1'b1}} << w;
    msb  = 6'(w - 1);
    return (sgn && v[msb]) ? (v | mask) : (v & ~mask);
  endfunction
endpackage

// File: rtl/ffra_acc.sv
// Output-stage accumulator: load or add p into o, flag overflow.
// FFRA_MAC_SAT_EN selects clamping instead of wrap-around on overflow.
module ffra_acc
  import ffra_pkg::*;
#(
  parameter int PW     = 17,
  parameter int ACC_W  = 20,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PW-1:0]    p,
  input  logic             acc,
  input  logic             load,
  output logic [ACC_W-1:0] o,
  output logic             ovf_pulse
);
  logic [ACC_W-1:0] ep, nxt, sat;
  logic [ACC_W:0]   sum;
  logic             ovf_c;

  assign ep  = ACC_W'(ext(EXT_W'(p), PW, SIGNED != 0));
  assign sum = {1'b0, o} + {1'b0, ep};

  always_comb begin
    ovf_c = 1'b0;
    sat   = {ACC_W{1'b1}};
    if (SIGNED != 0) begin
      // Like-signed operands producing an opposite-signed sum overflowed.
      ovf_c = (o[ACC_W-1] == ep[ACC_W-1]) && (sum[ACC_W-1] != o[ACC_W-1]);
      sat   = o[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      ovf_c = sum[ACC_W];
    end
  end

`ifdef FFRA_MAC_SAT_EN
  assign nxt = ovf_c ? sat : sum[ACC_W-1:0];
`else
  assign nxt = sum[ACC_W-1:0];
  logic unused_sat;
  assign unused_sat = ^sat;
`endif

  assign ovf_pulse = load && (acc == ACC_ADD) && ovf_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    o <= '0;
    else if (load) o <= (acc == ACC_ADD) ? nxt : ep;
  end
endmodule

// File: rtl/ffra_mac.sv
// Pipelined p = a*b + c with output accumulator, whole-pipeline stall and sticky ovf.
// Optional FFRA_MAC_SAT_EN: saturate the accumulator on overflow.
module ffra_mac
  import ffra_pkg::*;
#(
  parameter int BITS   = 8,
  parameter int DEPTH  = 4,
  parameter int GUARD  = 4,
  parameter int SIGNED = 0,
  localparam int ACC_W = acc_w(BITS, GUARD)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BITS-1:0]   a,
  input  logic [BITS-1:0]   b,
  input  logic [2*BITS-1:0] c,
  input  logic              acc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  o,
  output logic              ovf,
  input  logic              ovf_clr
);
  localparam int PW = 2 * BITS + 1;
  localparam int ST = DEPTH - 1;  // registers ahead of the output stage

  logic [PW-1:0]         a_x, b_x, c_x, p_in;
  logic [ST-1:0][PW-1:0] p_pipe;
  logic [ST-1:0]         acc_pipe;
  logic [ST:0]           vld_pipe;
  logic                  advance, load, ovf_pulse;

  assign a_x  = PW'(ext(EXT_W'(a), BITS, SIGNED != 0));
  assign b_x  = PW'(ext(EXT_W'(b), BITS, SIGNED != 0));
  assign c_x  = PW'(ext(EXT_W'(c), 2 * BITS, SIGNED != 0));
  // Exact in PW bits for either signedness, so mod-2^PW arithmetic suffices.
  assign p_in = a_x * b_x + c_x;

  assign advance   = !vld_pipe[ST] || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_pipe[ST];
  assign load      = advance && vld_pipe[ST-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      p_pipe   <= '0;
      acc_pipe <= '0;
    end else if (advance) begin
      vld_pipe[0] <= in_valid;
      p_pipe[0]   <= p_in;
      acc_pipe[0] <= acc;
      for (int i = 1; i < ST; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        p_pipe[i]   <= p_pipe[i-1];
        acc_pipe[i] <= acc_pipe[i-1];
      end
      vld_pipe[ST] <= vld_pipe[ST-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         ovf <= 1'b0;
    else if (ovf_pulse) ovf <= 1'b1;
    else if (ovf_clr)   ovf <= 1'b0;
  end

  ffra_acc #(.PW(PW), .ACC_W(ACC_W), .SIGNED(SIGNED)) u_acc (
    .clk       (clk),
    .rst_n     (rst_n),
    .p         (p_pipe[ST-1]),
    .acc       (acc_pipe[ST-1]),
    .load      (load),
    .o         (o),
    .ovf_pulse (ovf_pulse)
  );
endmodule

// File: tb/tb_ffra_mac.sv
// Directed bench for ffra_mac: vector table plus stall, reset and signed sequences.
module tb_ffra_mac;
  localparam int DEPTH = 4;

  typedef struct {
    logic [7:0]  a, b;
    logic [15:0] c;
    logic        acc;
    logic [19:0] eo;
    logic        eovf;
  } vec_t;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b1, ovf_clr = 1'b0, acc = 1'b0;
  logic [7:0]  a = '0, b = '0;
  logic [15:0] c = '0;
  logic        in_ready, out_valid, ovf;
  logic [19:0] o;

  logic        s_in_valid = 1'b0, s_acc = 1'b0;
  logic [7:0]  s_a = '0, s_b = '0;
  logic [15:0] s_c = '0;
  logic        s_in_ready, s_out_valid, s_ovf;
  logic [19:0] s_o;

  int n_cmp = 0, n_bad = 0;
  vec_t vt [12];

  always #5 clk = ~clk;

  ffra_mac #(.BITS(8), .DEPTH(DEPTH), .GUARD(4), .SIGNED(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .acc(acc), .out_valid(out_valid), .out_ready(out_ready),
    .o(o), .ovf(ovf), .ovf_clr(ovf_clr));

  ffra_mac #(.BITS(8), .DEPTH(DEPTH), .GUARD(4), .SIGNED(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .a(s_a), .b(s_b), .c(s_c), .acc(s_acc), .out_valid(s_out_valid), .out_ready(1'b1),
    .o(s_o), .ovf(s_ovf), .ovf_clr(1'b0));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic beat(input logic [7:0] va, input logic [7:0] vb, input logic [15:0] vc,
                      input logic vacc);
    in_valid = 1'b1; a = va; b = vb; c = vc; acc = vacc;
  endtask

  // Single beat, then wait out the latency and compare the result.
  task automatic apply(input int i, input bit clr);
    @(negedge clk);
    beat(vt[i].a, vt[i].b, vt[i].c, vt[i].acc);
    ovf_clr = clr;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (DEPTH - 1) @(negedge clk);
    check($sformatf("vec%0d out_valid", i), 32'(out_valid), 1);
    check($sformatf("vec%0d o", i), 32'(o), 32'(vt[i].eo));
    check($sformatf("vec%0d ovf", i), 32'(ovf), 32'(vt[i].eovf));
  endtask

  initial begin
    vt[0]  = '{8'd3,   8'd5,   16'd7,     1'b0, 20'd22,      1'b0};
    vt[1]  = '{8'd2,   8'd2,   16'd0,     1'b1, 20'd26,      1'b0};
    vt[2]  = '{8'd1,   8'd1,   16'd1,     1'b1, 20'd28,      1'b0};
    vt[3]  = '{8'd255, 8'd255, 16'd65535, 1'b0, 20'd130560,  1'b0};
    vt[4]  = '{8'd255, 8'd255, 16'd65535, 1'b1, 20'd261120,  1'b0};
    vt[5]  = '{8'd255, 8'd255, 16'd65535, 1'b1, 20'd391680,  1'b0};
    vt[6]  = '{8'd255, 8'd255, 16'd65535, 1'b1, 20'd522240,  1'b0};
    vt[7]  = '{8'd255, 8'd255, 16'd65535, 1'b1, 20'd652800,  1'b0};
    vt[8]  = '{8'd255, 8'd255, 16'd65535, 1'b1, 20'd783360,  1'b0};
    vt[9]  = '{8'd255, 8'd255, 16'd65535, 1'b1, 20'd913920,  1'b0};
    vt[10] = '{8'd255, 8'd255, 16'd65535, 1'b1, 20'd1044480, 1'b0};
`ifdef FFRA_MAC_SAT_EN
    vt[11] = '{8'd255, 8'd255, 16'd65535, 1'b1, 20'd1048575, 1'b1};
`else
    vt[11] = '{8'd255, 8'd255, 16'd65535, 1'b1, 20'd126464,  1'b1};
`endif

    // Reset state
    #12;
    check("rst out_valid", 32'(out_valid), 0);
    check("rst o", 32'(o), 0);
    check("rst ovf", 32'(ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    check("idle in_ready", 32'(in_ready), 1);

    for (int i = 0; i < 12; i++) apply(i, 1'b0);

    // Reset while beats are in flight (ovf is set from the wrap vector)
    @(negedge clk); beat(8'd3, 8'd5, 16'd7, 1'b0);
    @(negedge clk); beat(8'd2, 8'd2, 16'd0, 1'b1);
    @(negedge clk); beat(8'd1, 8'd1, 16'd1, 1'b1);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    check("pre-rst o", 32'(o), 22);
    #2 rst_n = 1'b0;
    #1;
    check("async rst out_valid", 32'(out_valid), 0);
    check("async rst o", 32'(o), 0);
    check("async rst ovf", 32'(ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("post-rst stale k%0d", k), 32'(out_valid), 0);
    end

    // Streaming accumulate: load then two accumulates back to back
    @(negedge clk); beat(8'd3, 8'd5, 16'd7, 1'b0);
    @(negedge clk); beat(8'd2, 8'd2, 16'd0, 1'b1);
    @(negedge clk); beat(8'd1, 8'd1, 16'd1, 1'b1);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); check("stream o0", 32'(o), 22); check("stream v0", 32'(out_valid), 1);
    @(negedge clk); check("stream o1", 32'(o), 26); check("stream v1", 32'(out_valid), 1);
    @(negedge clk); check("stream o2", 32'(o), 28); check("stream v2", 32'(out_valid), 1);
    @(negedge clk); check("stream drop", 32'(out_valid), 0); check("stream hold", 32'(o), 28);

    // Backpressure: four beats, output stalled for three cycles
    out_ready = 1'b0;
    @(negedge clk); beat(8'd3, 8'd5, 16'd7, 1'b0);
    @(negedge clk); beat(8'd2, 8'd2, 16'd0, 1'b1);
    @(negedge clk); beat(8'd1, 8'd1, 16'd1, 1'b1);
    @(negedge clk); beat(8'd1, 8'd2, 16'd3, 1'b1);
    @(negedge clk); in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stall%0d in_ready", k), 32'(in_ready), 0);
      check($sformatf("stall%0d o", k), 32'(o), 22);
      check($sformatf("stall%0d valid", k), 32'(out_valid), 1);
      if (k < 2) @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk); check("bp o1", 32'(o), 26); check("bp v1", 32'(out_valid), 1);
    @(negedge clk); check("bp o2", 32'(o), 28); check("bp v2", 32'(out_valid), 1);
    @(negedge clk); check("bp o3", 32'(o), 33); check("bp v3", 32'(out_valid), 1);
    @(negedge clk); check("bp drop", 32'(out_valid), 0); check("bp hold", 32'(o), 33);

    // Wrap again; ovf_clr held across the overflowing beat: set wins, then clears
    for (int i = 3; i < 11; i++) apply(i, 1'b0);
    apply(11, 1'b1);
    @(negedge clk);
    check("ovf_clr clears", 32'(ovf), 0);
    ovf_clr = 1'b0;

    // Signed instance: -3*5 + -1 = -16, then +16 accumulates to 0
    @(negedge clk); s_in_valid = 1'b1; s_a = 8'hFD; s_b = 8'd5; s_c = 16'hFFFF; s_acc = 1'b0;
    @(negedge clk); s_a = 8'd4; s_b = 8'd4; s_c = 16'd0; s_acc = 1'b1;
    @(negedge clk); s_in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); check("sgn load o", 32'(s_o), 32'h000FFFF0);
    check("sgn load v", 32'(s_out_valid), 1);
    @(negedge clk); check("sgn acc o", 32'(s_o), 0);
    check("sgn ovf", 32'(s_ovf), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ffra_mac.md
Name: ffra_mac

Overview:
- Parametrised, pipelined multiply-add unit with an output accumulator.
- Computes p = a*b + c per beat. Each beat either loads p into the accumulator or adds p to it.
- Pipeline depth, operand width, guard bits and signedness are configurable.
- Valid/ready handshake with whole-pipeline stall. A sticky overflow flag is provided.
- Sits in the arithmetic datapath as the successor to the fixed 4-deep multiply-add delay line.

Parameters:
- BITS, 8: width of a and b; c is 2*BITS wide.
- DEPTH, 4: pipeline latency in cycles. Must be at least 2. The output register counts as the last stage.
- GUARD, 4: extra accumulator bits. ACC_W = 2*BITS+GUARD. Must be at least 1.
- SIGNED, 0: 0 = unsigned operands; 1 = two's-complement a, b and c.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- a  in  BITS  multiplicand.
- b  in  BITS  multiplier.
- c  in  2*BITS  addend.
- acc  in  1  0 = load p into accumulator; 1 = add p to accumulator.
- out_valid  out  1  o holds a fresh result.
- out_ready  in  1  downstream accepts result.
- o  out  ACC_W  accumulator / result value.
- ovf  out  1  sticky accumulator overflow flag.
- ovf_clr  in  1  synchronous clear of ovf.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All stage valid bits = 0, o = 0, ovf = 0; stage data registers = 0.
  - In-flight beats are discarded. No beat emerges after release.
- Advance = !out_valid || out_ready. in_ready = advance (combinational).
- On advance, every stage shifts one place, bubbles included. Otherwise every stage holds.
- Latency: a beat accepted at edge t gives out_valid = 1 after edge t+DEPTH-1, with no stalls. Full throughput is one beat per cycle.
- Stage 0 computes p = a*b + c, exact, in 2*BITS+1 bits:
  - SIGNED = 0: zero-extend operands.
  - SIGNED = 1: sign-extend operands.
  - No overflow is possible at stage 0.
  - The acc bit travels with p through stages 1..DEPTH-2.
- Output stage, when a valid beat shifts in:
  - acc = 0: o <= ext(p) to ACC_W. No overflow possible.
  - acc = 1: o <= o + ext(p).
  - Overflow means unsigned carry-out (SIGNED = 0) or signed overflow (SIGNED = 1). On overflow the result wraps modulo 2^ACC_W and ovf is set.
- Bubble shifting into the output stage: out_valid <= 0 and o holds its value, so the accumulator is preserved across gaps.
- The accumulator update happens only on the shift into the output stage. A stalled output (out_valid && !out_ready) is never re-accumulated.
- ovf_clr and a new overflow in the same cycle: set wins, ovf = 1.
- An acc = 1 beat after reset accumulates onto o = 0.

Optional Feature:
- Macro: FFRA_MAC_SAT_EN.
- Defined: accumulate overflow clamps o instead of wrapping.
  - Unsigned: clamps to 2^ACC_W-1.
  - Signed: clamps to 2^(ACC_W-1)-1 on positive overflow, -2^(ACC_W-1) on negative overflow.
  - ovf is still set.
- Undefined: wrap-around as described in Behaviour.

Decomposition:
- Package ffra_pkg: ACC_W derivation function, ACC_LOAD/ACC_ADD mode constants, and a sign/zero-extend helper function.
- Natural sub-module ffra_acc: output-stage accumulator.
  - Inputs: p, acc, load strobe.
  - Outputs: o, overflow pulse.
  - Contains the wrap/saturate logic selected by FFRA_MAC_SAT_EN.
- The top level holds the pipeline, valid bits, handshake and ovf flag.

Test Plan:
All scenarios use BITS=8, DEPTH=4, GUARD=4 (ACC_W=20) and SIGNED=0 unless stated.
- Load: a=3, b=5, c=7, acc=0 accepted at edge 0, out_ready=1 → out_valid=1 after edge 3, o=22, ovf=0.
- Accumulate streaming: back-to-back beats (3,5,7,load), (2,2,0,acc), (1,1,1,acc) → o=22, 26, 28 on three consecutive cycles; out_valid then drops and o stays 28.
- Backpressure: out_ready=0 for 3 cycles while the first result is valid, with 3 more beats pending.
  - Required: in_ready=0 and o holds 22 during the stall.
  - After release, results follow in order with no loss or duplication.
- Wrap overflow: load (255,255,65535) → p=130560, then 8 acc beats of the same.
  - The 8th acc beat gives 1175040 mod 2^20 = 126464 and ovf=1.
  - With FFRA_MAC_SAT_EN: o=1048575, ovf=1.
  - ovf_clr then clears ovf.
- Signed: SIGNED=1, a=0xFD (-3), b=5, c=0xFFFF (-1), load → o=0xFFFF0 (-16). A following acc beat with a=4, b=4, c=0 gives o=0.
- Reset mid-operation: rst_n low while 3 beats are in flight → out_valid=0, o=0, ovf=0 immediately (asynchronous). After release, no stale beat appears.
